// File: rtl/fwd_track_unit.sv
// Operand-forwarding / load-use tracker: shift register of in-flight rd writes, per-operand youngest match.
// Forwarding and stall outputs are combinational (zero latency); entries move only on adv_i, and the stall holds decode.
module fwd_track_unit #(
   parameter int NUM_SRC    = 2,
   parameter int FWD_STAGES = 2,
   parameter int REG_AW     = 5,
   parameter int SW         = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      adv_i,
   input  logic                      flush_i,
   input  logic                      dec_valid_i,
   input  logic                      dec_we_i,
   input  logic [REG_AW-1:0]         dec_rd_i,
   input  logic [2:0]                dec_kind_i,
   input  logic [NUM_SRC*REG_AW-1:0] src_rs_i,
   input  logic [NUM_SRC-1:0]        src_use_i,
   output logic [NUM_SRC-1:0]        fwd_hit_o,
   output logic [NUM_SRC*SW-1:0]     fwd_stage_o,
   output logic [NUM_SRC*3-1:0]      fwd_kind_o,
   output logic                      stall_o,
   output logic [31:0]               stall_cnt_o
);

   localparam logic [2:0] KIND_LOAD = 3'd4;

   typedef struct packed {
      logic              vld;
      logic [REG_AW-1:0] rd;
      logic [2:0]        kind;
   } entry_t;

   entry_t      stage_q [FWD_STAGES];
   logic [31:0] stall_cnt_q;
   logic        ins_vld;

   // A stalled or flushed decode slot enters the table as a bubble; x0 is never recorded.
   assign ins_vld = dec_valid_i & dec_we_i & (dec_rd_i != '0) & ~stall_o & ~flush_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < FWD_STAGES; k++) begin
            stage_q[k] <= '0;
         end
         stall_cnt_q <= '0;
      end else begin
         if (adv_i) begin
            for (int k = FWD_STAGES - 1; k >= 1; k--) begin
               stage_q[k] <= stage_q[k-1];
            end
            stage_q[0] <= '{vld: ins_vld, rd: dec_rd_i, kind: dec_kind_i};
         end else if (flush_i) begin
            stage_q[0].vld <= 1'b0;
         end
         if (stall_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
      end
   end

   // Scan oldest to youngest so the youngest match overwrites older ones.
   always_comb begin
      fwd_hit_o   = '0;
      fwd_stage_o = '0;
      fwd_kind_o  = '0;
      stall_o     = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         for (int k = FWD_STAGES - 1; k >= 0; k--) begin
            if (src_use_i[i] && stage_q[k].vld &&
                (stage_q[k].rd == src_rs_i[i*REG_AW +: REG_AW]) &&
                (src_rs_i[i*REG_AW +: REG_AW] != '0)) begin
               fwd_hit_o[i]           = 1'b1;
               fwd_stage_o[i*SW +: SW] = SW'(k);
               fwd_kind_o[i*3 +: 3]   = stage_q[k].kind;
            end
         end
         if (fwd_hit_o[i] && (fwd_stage_o[i*SW +: SW] == '0) &&
             (fwd_kind_o[i*3 +: 3] == KIND_LOAD)) begin
            stall_o = 1'b1;
         end
      end
   end

   assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_fwd_track_unit.sv
// Bench for fwd_track_unit: directed scenarios plus random traffic against a list-based reference model.
module tb_fwd_track_unit;

   logic        clk;
   logic        rst_n;
   logic        adv_i;
   logic        flush_i;
   logic        dec_valid_i;
   logic        dec_we_i;
   logic [4:0]  dec_rd_i;
   logic [2:0]  dec_kind_i;
   logic [9:0]  src_rs_i;
   logic [1:0]  src_use_i;
   logic [1:0]  fwd_hit_o;
   logic [1:0]  fwd_stage_o;
   logic [5:0]  fwd_kind_o;
   logic        stall_o;
   logic [31:0] stall_cnt_o;

   int n_checks = 0;
   int n_err    = 0;

   // Reference: in-flight list, index 0 = youngest.
   logic        m_vld  [2];
   logic [4:0]  m_rd   [2];
   logic [2:0]  m_kind [2];
   logic [31:0] m_cnt;

   fwd_track_unit #(.NUM_SRC(2), .FWD_STAGES(2), .REG_AW(5), .SW(1)) dut (
      .clk(clk), .rst_n(rst_n), .adv_i(adv_i), .flush_i(flush_i),
      .dec_valid_i(dec_valid_i), .dec_we_i(dec_we_i), .dec_rd_i(dec_rd_i),
      .dec_kind_i(dec_kind_i), .src_rs_i(src_rs_i), .src_use_i(src_use_i),
      .fwd_hit_o(fwd_hit_o), .fwd_stage_o(fwd_stage_o), .fwd_kind_o(fwd_kind_o),
      .stall_o(stall_o), .stall_cnt_o(stall_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected {hit[1:0], stage[1:0], kind[5:0], stall}
   function automatic logic [10:0] model_out();
      logic [1:0] h;
      logic [1:0] s;
      logic [5:0] kd;
      logic       st;
      logic [4:0] rs;
      h = '0; s = '0; kd = '0; st = 1'b0;
      for (int i = 0; i < 2; i++) begin
         rs = src_rs_i[i*5 +: 5];
         for (int k = 0; k < 2; k++) begin
            if (!h[i] && src_use_i[i] && rs != 5'd0 && m_vld[k] && m_rd[k] == rs) begin
               h[i] = 1'b1;
               s[i] = (k == 1);
               kd[i*3 +: 3] = m_kind[k];
               if (k == 0 && m_kind[k] == 3'd4) st = 1'b1;
            end
         end
      end
      return {h, s, kd, st};
   endfunction

   function automatic logic [10:0] dut_out();
      return {fwd_hit_o, fwd_stage_o, fwd_kind_o, stall_o};
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_vld[k] = 1'b0; m_rd[k] = '0; m_kind[k] = '0;
      end
      m_cnt = '0;
   endtask

   task automatic drive(input logic v, input logic we, input logic [4:0] rd, input logic [2:0] kind,
                        input logic adv, input logic fl, input logic [4:0] rs0, input logic [4:0] rs1,
                        input logic [1:0] use_v);
      dec_valid_i = v; dec_we_i = we; dec_rd_i = rd; dec_kind_i = kind;
      adv_i = adv; flush_i = fl; src_rs_i = {rs1, rs0}; src_use_i = use_v;
   endtask

   // One clock edge; the model advances with the inputs held across it. Returns at the next negedge.
   task automatic tick();
      logic [10:0] e;
      logic        st;
      e  = model_out();
      st = e[0];
      @(posedge clk);
      if (adv_i) begin
         m_vld[1] = m_vld[0]; m_rd[1] = m_rd[0]; m_kind[1] = m_kind[0];
         m_vld[0] = dec_valid_i && dec_we_i && dec_rd_i != 5'd0 && !st && !flush_i;
         m_rd[0] = dec_rd_i; m_kind[0] = dec_kind_i;
      end else if (flush_i) begin
         m_vld[0] = 1'b0;
      end
      if (st && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      model_reset();
      drive(0, 0, 0, 0, 0, 0, 5'd1, 5'd2, 2'b11);
      #1;
      n_checks++;
      if (dut_out() !== 11'd0) begin
         n_err++; $display("FAIL reset_outputs: got %h required %h", dut_out(), 11'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (dut_out() !== model_out() || stall_cnt_o !== 32'd0) begin
         n_err++; $display("FAIL reset_release: got %h cnt %h required %h cnt 0", dut_out(), stall_cnt_o, model_out());
      end
   endtask

   task automatic test_ex_forward();
      drive(1, 1, 5'd5, 3'd0, 1, 0, 5'd0, 5'd0, 2'b00);
      tick();
      drive(0, 0, 5'd0, 3'd0, 0, 0, 5'd5, 5'd6, 2'b11);
      #1;
      n_checks++;
      if (dut_out() !== model_out() || fwd_hit_o !== 2'b01 || fwd_stage_o[0] !== 1'b0) begin
         n_err++; $display("FAIL ex_fwd_stage0: got %h required %h", dut_out(), model_out());
      end
      adv_i = 1'b1;
      tick();
      adv_i = 1'b0;
      #1;
      n_checks++;
      if (dut_out() !== model_out() || fwd_stage_o[0] !== 1'b1) begin
         n_err++; $display("FAIL ex_fwd_stage1: got %h required %h", dut_out(), model_out());
      end
   endtask

   task automatic test_youngest_wins();
      drive(1, 1, 5'd7, 3'd2, 1, 0, 5'd0, 5'd0, 2'b00);
      tick();
      drive(1, 1, 5'd7, 3'd3, 1, 0, 5'd0, 5'd0, 2'b00);
      tick();
      drive(0, 0, 5'd0, 3'd0, 0, 0, 5'd7, 5'd7, 2'b11);
      #1;
      n_checks++;
      if (dut_out() !== model_out() || fwd_hit_o !== 2'b11 || fwd_stage_o !== 2'b00 || fwd_kind_o !== 6'b011_011) begin
         n_err++; $display("FAIL youngest_wins: got %h required %h", dut_out(), model_out());
      end
   endtask

   task automatic test_load_use();
      drive(1, 1, 5'd9, 3'd4, 1, 0, 5'd0, 5'd0, 2'b00);
      tick();
      drive(1, 1, 5'd12, 3'd0, 1, 0, 5'd9, 5'd0, 2'b01);
      #1;
      n_checks++;
      if (stall_o !== 1'b1 || dut_out() !== model_out()) begin
         n_err++; $display("FAIL load_use_stall: got %h required %h", dut_out(), model_out());
      end
      tick();
      drive(0, 0, 5'd0, 3'd0, 0, 0, 5'd9, 5'd12, 2'b11);
      #1;
      n_checks++;
      if (dut_out() !== model_out() || stall_o !== 1'b0 || fwd_hit_o !== 2'b01 ||
          fwd_stage_o[0] !== 1'b1 || fwd_kind_o[2:0] !== 3'd4) begin
         n_err++; $display("FAIL load_use_after: got %h required %h", dut_out(), model_out());
      end
      n_checks++;
      if (stall_cnt_o !== m_cnt) begin
         n_err++; $display("FAIL load_use_cnt: got %h required %h", stall_cnt_o, m_cnt);
      end
   endtask

   task automatic test_x0_unused();
      drive(1, 1, 5'd0, 3'd0, 1, 0, 5'd0, 5'd0, 2'b00);
      tick();
      drive(1, 1, 5'd3, 3'd1, 1, 0, 5'd0, 5'd0, 2'b00);
      tick();
      drive(0, 0, 5'd0, 3'd0, 0, 0, 5'd3, 5'd3, 2'b10);
      #1;
      n_checks++;
      if (dut_out() !== model_out() || fwd_hit_o !== 2'b10) begin
         n_err++; $display("FAIL x0_unused: got %h required %h", dut_out(), model_out());
      end
      src_rs_i = '0; src_use_i = 2'b11;
      #1;
      n_checks++;
      if (fwd_hit_o !== 2'b00) begin
         n_err++; $display("FAIL x0_read: got hit %b required 00", fwd_hit_o);
      end
   endtask

   task automatic test_flush();
      drive(1, 1, 5'd11, 3'd0, 1, 1, 5'd0, 5'd0, 2'b00);
      tick();
      drive(0, 0, 5'd0, 3'd0, 0, 0, 5'd11, 5'd11, 2'b11);
      #1;
      n_checks++;
      if (dut_out() !== model_out() || fwd_hit_o !== 2'b00) begin
         n_err++; $display("FAIL flush_insert: got %h required %h", dut_out(), model_out());
      end
      drive(1, 1, 5'd11, 3'd5, 1, 0, 5'd0, 5'd0, 2'b00);
      tick();
      drive(0, 0, 5'd0, 3'd0, 0, 0, 5'd11, 5'd0, 2'b01);
      #1;
      n_checks++;
      if (dut_out() !== model_out() || fwd_kind_o[2:0] !== 3'd5 || stall_o !== 1'b0) begin
         n_err++; $display("FAIL reserved_kind: got %h required %h", dut_out(), model_out());
      end
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      #1;
      n_checks++;
      if (dut_out() !== model_out() || fwd_hit_o !== 2'b00) begin
         n_err++; $display("FAIL flush_hold: got %h required %h", dut_out(), model_out());
      end
   endtask

   task automatic test_saturation();
      drive(1, 1, 5'd9, 3'd4, 1, 0, 5'd0, 5'd0, 2'b00);
      tick();
      drive(0, 0, 5'd0, 3'd0, 0, 0, 5'd9, 5'd0, 2'b01);
      force dut.stall_cnt_q = 32'hFFFF_FFFE;
      #1;
      release dut.stall_cnt_q;
      m_cnt = 32'hFFFF_FFFE;
      for (int c = 0; c < 3; c++) tick();
      #1;
      n_checks++;
      if (stall_cnt_o !== 32'hFFFF_FFFF || stall_cnt_o !== m_cnt) begin
         n_err++; $display("FAIL saturate: got %h required %h", stall_cnt_o, 32'hFFFF_FFFF);
      end
      n_checks++;
      if (stall_o !== 1'b1) begin
         n_err++; $display("FAIL saturate_stall: got %b required 1", stall_o);
      end
   endtask

   task automatic test_reset_mid();
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      n_checks++;
      if (dut_out() !== 11'd0 || stall_cnt_o !== 32'd0) begin
         n_err++; $display("FAIL reset_mid: got %h cnt %h required 0 cnt 0", dut_out(), stall_cnt_o);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_random();
      logic [1:0] use_v;
      for (int c = 0; c < 400; c++) begin
         use_v = 2'($urandom_range(0, 3));
         drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
               5'($urandom_range(0, 5)), 3'($urandom_range(0, 7)),
               1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0),
               5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)), use_v);
         #1;
         n_checks++;
         if (dut_out() !== model_out() || stall_cnt_o !== m_cnt) begin
            n_err++;
            $display("FAIL random_c%0d: got %h cnt %h required %h cnt %h", c, dut_out(), stall_cnt_o, model_out(), m_cnt);
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_ex_forward();
      test_youngest_wins();
      test_load_use();
      test_x0_unused();
      test_flush();
      test_saturation();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/fwd_track_unit.md
Name: fwd_track_unit

Overview:
- Parametrised operand-forwarding and load-use hazard tracker for the 5-stage RV32I pipeline.
- Replaces fixed per-mux forwarding select encodings with a generic tracker, sized by NUM_SRC operands and FWD_STAGES in-flight stages.
- Holds a shift register of in-flight register writes (rd, result kind) and reports, per source operand, which stage and result kind to forward.
- Raises a stall on a load-use hazard and counts stall cycles.

Parameters:
- NUM_SRC, 2, number of source operands checked each cycle (rs1, rs2, ...).
- FWD_STAGES, 2, in-flight stages tracked; stage 0 is youngest (EX/MEM), stage FWD_STAGES-1 is oldest (MEM/WB).
- REG_AW, 5, register address width.
- SW, 1, stage index width; equals max(1, clog2(FWD_STAGES)).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- adv_i  in  1  pipeline advance (global stall deasserted).
- flush_i  in  1  kill the instruction being inserted and the stage-0 entry.
- dec_valid_i  in  1  instruction leaving decode.
- dec_we_i  in  1  instruction writes rd.
- dec_rd_i  in  REG_AW  destination register.
- dec_kind_i  in  3  result kind: 0 alu_out, 1 br_en, 2 u_imm, 3 pc_plus4, 4 read_data; 5-7 reserved.
- src_rs_i  in  NUM_SRC*REG_AW  source register addresses, operand i at slice i.
- src_use_i  in  NUM_SRC  operand i is actually read.
- fwd_hit_o  out  NUM_SRC  operand i must be forwarded.
- fwd_stage_o  out  NUM_SRC*SW  stage supplying operand i.
- fwd_kind_o  out  NUM_SRC*3  result kind to select within that stage.
- stall_o  out  1  load-use hazard; decode must hold.
- stall_cnt_o  out  32  saturating count of stall cycles.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - all entries valid=0, rd=0, kind=0.
  - stall_cnt_o=0.
  - fwd_hit_o=0, fwd_stage_o=0, fwd_kind_o=0.
  - stall_o=0 (follows from the empty table).
- Reset mid-operation clears every entry in the same cycle, with no drain.
- Entry state per stage k: valid, rd, kind.
- Write-back on posedge when adv_i=1:
  - For k ≥ 1, stage[k] <= stage[k-1]. The oldest entry is dropped.
  - Stage[0] <= {dec_valid_i & dec_we_i & (dec_rd_i≠0) & ~stall_o & ~flush_i, dec_rd_i, dec_kind_i}.
- When adv_i=0, all entries hold. flush_i with adv_i=0 clears stage[0].valid only.
- Forwarding outputs are combinational from state and src inputs, with zero latency.
- Match rule: operand i matches stage k iff src_use_i[i], stage[k].valid, stage[k].rd==src_rs_i[i], and src_rs_i[i]≠0.
- Priority: the lowest k (youngest) wins.
- On a match: fwd_hit_o[i]=1, fwd_stage_o=k, fwd_kind_o=stage[k].kind.
- With no match, all three fields for operand i are 0 and the register file is used.
- stall_o=1 iff any operand's winning match is stage 0 with kind==4 (load data not yet available).
  - In that case fwd_hit_o for that operand is still reported; the consumer ignores it while stalled.
  - An older read_data match is forwardable and does not stall.
- Stall counter: increments on posedge when stall_o=1, independent of adv_i. It saturates at 0xFFFFFFFF with no wrap.
- Simultaneous stall_o and flush_i: flush wins and a bubble is inserted.
- Simultaneous stall_o and adv_i: older stages shift and a bubble enters stage 0.
- Reserved kinds 5-7 are stored and forwarded unchanged and never stall.
- x0 writes are never recorded; x0 reads never match.

Test Plan:
1. Reset and empty table:
   - Stimulus: rst_n low, then high; src_rs={1,2}, use=11.
   - Required: fwd_hit=00, stall=0, stall_cnt=0.
2. EX forwarding:
   - Stimulus: insert rd=5 kind=0 with adv; next cycle src_rs={5,6}, use=11.
   - Required: hit=01, stage[0]=0, kind=0.
   - Stimulus: one more adv with a bubble.
   - Required: stage=1 for operand 0.
3. Youngest wins:
   - Stimulus: insert rd=7 kind=2, then rd=7 kind=3; src_rs={7,7}.
   - Required: both operands hit, stage=0, kind=3.
4. Load-use:
   - Stimulus: insert rd=9 kind=4; src_rs={9,0}, use=01, adv=1.
   - Required: stall=1; next edge stage0 is a bubble, stage1 holds rd=9.
   - Required next cycle: stall=0, hit stage=1, kind=4, stall_cnt=1.
5. x0 and unused operand:
   - Stimulus: insert rd=0 kind=0 → stage0.valid=0. Insert rd=3, then src_rs={3,3} with use=10.
   - Required: hit=10 only.
6. Flush and saturation:
   - Stimulus: flush_i with a valid insert.
   - Required: stage0 empty.
   - Stimulus: force stall_cnt to 0xFFFFFFFE, then 3 stall cycles.
   - Required: counter reads 0xFFFFFFFF.
   - Stimulus: assert rst_n low mid-stall.
   - Required: immediate clear.
